// File: rtl/hdmi_fifo_wr_arb.sv
// Round-robin, burst-granular write arbiter for the HDMI prefetch FIFO write port.
// Define HDMI_FIFO_WR_ARB_TIMEOUT_EN to enable the stalled-producer abort (TIMEOUT cycles).
module hdmi_fifo_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_gnt,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_valid,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic [NUM_REQ-1:0]        burst_done,
  input  logic                      fifo_wr_vld,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("hdmi_fifo_wr_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   sel_idx, cand_idx;
  logic               sel_found;
  logic               xfer;
  logic               last;
  logic               abort;
  int                 cand;

  // Round-robin search starting just above the last serviced producer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign busy         = (state_q == S_BURST);
  assign req_gnt      = gnt_q;
  assign xfer         = busy && s_valid[idx_q] && fifo_wr_vld;
  assign last         = xfer && (cnt_q == '0) && !abort;
  assign s_ready      = busy ? (gnt_q & {NUM_REQ{fifo_wr_vld}}) : '0;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = s_data[idx_q*DATA_W +: DATA_W];
  assign burst_done   = last ? gnt_q : '0;

`ifdef HDMI_FIFO_WR_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stall_cyc;

  // Only a silent producer counts as a stall; FIFO backpressure never does.
  assign stall_cyc   = busy && fifo_wr_vld && !s_valid[idx_q];
  assign abort       = busy && (stall_q == STALL_W'(TIMEOUT));
  assign err_timeout = abort;

  always_comb begin
    stall_d = stall_q;
    if (!busy || xfer || abort) begin
      stall_d = '0;
    end else if (stall_cyc) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_BURST;
          idx_d   = sel_idx;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          cnt_d   = req_len[sel_idx*LEN_W +: LEN_W];
        end
      end
      S_BURST: begin
        if (abort || last) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q;
        end else if (xfer) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registered state uses non-blocking assignments only.
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hdmi_fifo_wr_arb.sv
// Self-checking bench for hdmi_fifo_wr_arb: directed scenarios plus a randomized run
// against a transaction-level round-robin model.
module tb_hdmi_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int PW = 2;
`ifdef HDMI_FIFO_WR_ARB_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 1023;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_gnt;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N-1:0]    burst_done;
  logic            fifo_wr_vld;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            busy;
  logic            err_timeout;

  logic            pcnt_clr = 1'b0;
  int unsigned     pcnt [N];
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  hdmi_fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_len(req_len), .req_gnt(req_gnt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .burst_done(burst_done), .fifo_wr_vld(fifo_wr_vld),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Word k of producer p carries the producer id and its sequence number.
  function automatic logic [DW-1:0] word_of(input int p, input int unsigned k);
    logic [7:0]  pb;
    logic [23:0] kb;
    pb = 8'(p);
    kb = 24'(k);
    return {pb, kb};
  endfunction

  // Producers advance their stream only on an accepted handshake.
  always @(posedge clk) begin
    for (int p = 0; p < N; p++) begin
      if (pcnt_clr) pcnt[p] <= 0;
      else if (s_valid[p] && s_ready[p]) pcnt[p] <= pcnt[p] + 1;
    end
  end

  always_comb begin
    s_data = '0;
    for (int p = 0; p < N; p++) s_data[p*DW +: DW] = word_of(p, pcnt[p]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid   = '0;
    req_len     = '0;
    s_valid     = '0;
    fifo_wr_vld = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n    = 1'b0;
    pcnt_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pcnt_clr = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic clear_streams;
    pcnt_clr = 1'b1;
    tick();
    pcnt_clr = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n    = 1'b0;
    pcnt_clr = 1'b1;
    #2;
    total++;
    if ({req_gnt, s_ready, burst_done, fifo_wr_en, busy, err_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b rdy=%b done=%b en=%b busy=%b err=%b, want all 0",
               req_gnt, s_ready, burst_done, fifo_wr_en, busy, err_timeout);
    end
    repeat (2) @(posedge clk);
    #1;
    pcnt_clr    = 1'b0;
    rst_n       = 1'b1;
    fifo_wr_vld = 1'b1;
    s_valid     = '1;
    @(negedge clk);
    total++;
    if ({req_gnt, s_ready, fifo_wr_en, busy} !== '0) begin
      bad++;
      $display("FAIL idle_no_req: gnt=%b rdy=%b en=%b busy=%b, want all 0",
               req_gnt, s_ready, fifo_wr_en, busy);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_burst;
    logic [N-1:0] exp_done;
    clear_streams();
    fifo_wr_vld     = 1'b1;
    s_valid         = 4'b0001;
    req_len[0 +: LW] = 8'd3;
    req_valid       = 4'b0001;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_gnt !== 4'b0000) begin
      bad++;
      $display("FAIL single_pre_grant: busy=%b gnt=%b, want 0 0000", busy, req_gnt);
    end
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_done = (i == 3) ? 4'b0001 : 4'b0000;
      total++;
      if (req_gnt !== 4'b0001 || busy !== 1'b1 || fifo_wr_en !== 1'b1 ||
          fifo_wr_data !== word_of(0, i) || burst_done !== exp_done) begin
        bad++;
        $display("FAIL single_word%0d: gnt=%b busy=%b en=%b data=%h done=%b, want 0001 1 1 %h %b",
                 i, req_gnt, busy, fifo_wr_en, fifo_wr_data, burst_done, word_of(0, i), exp_done);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_gnt !== 4'b0000) begin
      bad++;
      $display("FAIL single_end: busy=%b en=%b gnt=%b, want 0 0 0000", busy, fifo_wr_en, req_gnt);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg;
    do_reset();
    fifo_wr_vld = 1'b1;
    s_valid     = '1;
    req_len     = '0;
    req_valid   = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap%0d: busy=%b en=%b, want 0 0", k, busy, fifo_wr_en);
      end
      tick();
      @(negedge clk);
      eg = '0;
      eg[k % N] = 1'b1;
      total++;
      if (req_gnt !== eg || fifo_wr_en !== 1'b1 || burst_done !== eg ||
          fifo_wr_data !== word_of(k % N, k / N)) begin
        bad++;
        $display("FAIL rr_grant%0d: gnt=%b en=%b done=%b data=%h, want %b 1 %b %h",
                 k, req_gnt, fifo_wr_en, burst_done, fifo_wr_data, eg, eg, word_of(k % N, k / N));
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure;
    int nwr;
    int cyc;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_done;
    clear_streams();
    req_len[2*LW +: LW] = 8'd7;
    req_valid   = 4'b0100;
    s_valid     = 4'b0100;
    fifo_wr_vld = 1'b1;
    tick();
    req_valid = '0;
    nwr = 0;
    cyc = 0;
    while (nwr < 8 && cyc < 64) begin
      fifo_wr_vld = (cyc % 4 == 0) || (cyc % 4 == 3);
      s_valid     = 4'b0100 | (4'($urandom) & 4'b1011);
      @(negedge clk);
      exp_rdy  = fifo_wr_vld ? 4'b0100 : 4'b0000;
      exp_done = (fifo_wr_vld && nwr == 7) ? 4'b0100 : 4'b0000;
      total++;
      if (s_ready !== exp_rdy || fifo_wr_en !== fifo_wr_vld || burst_done !== exp_done ||
          req_gnt !== 4'b0100) begin
        bad++;
        $display("FAIL bp_cycle%0d: rdy=%b en=%b done=%b gnt=%b, want %b %b %b 0100",
                 cyc, s_ready, fifo_wr_en, burst_done, req_gnt, exp_rdy, fifo_wr_vld, exp_done);
      end
      if (fifo_wr_vld) begin
        total++;
        if (fifo_wr_data !== word_of(2, nwr)) begin
          bad++;
          $display("FAIL bp_data%0d: data=%h, want %h", nwr, fifo_wr_data, word_of(2, nwr));
        end
        nwr++;
      end
      cyc++;
      tick();
    end
    fifo_wr_vld = 1'b1;
    @(negedge clk);
    total++;
    if (nwr != 8 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || pcnt[2] != 8) begin
      bad++;
      $display("FAIL bp_end: writes=%0d busy=%b en=%b accepted=%0d, want 8 0 0 8",
               nwr, busy, fifo_wr_en, pcnt[2]);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_long_burst;
    logic [N-1:0] exp_done;
    clear_streams();
    req_len[0 +: LW] = 8'd255;
    req_valid   = 4'b0001;
    s_valid     = 4'b0011;
    fifo_wr_vld = 1'b1;
    tick();
    req_valid = '0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        req_valid         = 4'b0010;
        req_len[LW +: LW] = 8'd0;
      end
      @(negedge clk);
      exp_done = (i == 255) ? 4'b0001 : 4'b0000;
      total++;
      if (req_gnt !== 4'b0001 || fifo_wr_en !== 1'b1 || burst_done !== exp_done ||
          fifo_wr_data !== word_of(0, i)) begin
        bad++;
        $display("FAIL long_word%0d: gnt=%b en=%b done=%b data=%h, want 0001 1 %b %h",
                 i, req_gnt, fifo_wr_en, burst_done, fifo_wr_data, exp_done, word_of(0, i));
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_gnt !== 4'b0000) begin
      bad++;
      $display("FAIL long_gap: busy=%b gnt=%b, want 0 0000", busy, req_gnt);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    total++;
    if (req_gnt !== 4'b0010 || fifo_wr_en !== 1'b1 || burst_done !== 4'b0010 ||
        fifo_wr_data !== word_of(1, 0)) begin
      bad++;
      $display("FAIL long_next: gnt=%b en=%b done=%b data=%h, want 0010 1 0010 %h",
               req_gnt, fifo_wr_en, burst_done, fifo_wr_data, word_of(1, 0));
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst;
    req_len[3*LW +: LW] = 8'd20;
    req_valid   = 4'b1000;
    s_valid     = 4'b1000;
    fifo_wr_vld = 1'b1;
    tick();
    req_valid = '0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_gnt, s_ready, burst_done, fifo_wr_en, busy, err_timeout} !== '0) begin
      bad++;
      $display("FAIL rst_mid: gnt=%b rdy=%b done=%b en=%b busy=%b err=%b, want all 0",
               req_gnt, s_ready, burst_done, fifo_wr_en, busy, err_timeout);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_len   = '0;
    req_valid = '1;
    s_valid   = '1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_idle: busy=%b, want 0", busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (req_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rst_first_grant: gnt=%b, want 0001", req_gnt);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  // Transaction model: which producer owns the port, how many words remain,
  // and how many words of each producer's stream the FIFO should have seen.
  task automatic test_random;
    bit           m_busy;
    logic [PW-1:0] m_g;
    int           m_left;
    int           m_ptr;
    int unsigned  m_sent [N];
    logic [N-1:0] eg, erdy, edone;
    logic         een;
    int           c;
    bit           found;
    do_reset();
    m_busy = 1'b0;
    m_g    = '0;
    m_left = 0;
    m_ptr  = N - 1;
    for (int p = 0; p < N; p++) m_sent[p] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (req_gnt[p]) begin
          req_valid[p] = 1'b0;
        end else if (!req_valid[p] && $urandom_range(0, 3) == 0) begin
          req_valid[p]        = 1'b1;
          req_len[p*LW +: LW] = LW'($urandom_range(0, 6));
        end
        s_valid[p] = ($urandom_range(0, 3) != 0);
      end
      fifo_wr_vld = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      eg = '0;
      if (m_busy) eg[m_g] = 1'b1;
      erdy  = (m_busy && fifo_wr_vld) ? eg : '0;
      een   = m_busy && s_valid[m_g] && fifo_wr_vld;
      edone = (een && m_left == 0) ? eg : '0;
      total++;
      if ({busy, req_gnt, s_ready, fifo_wr_en, burst_done, err_timeout} !==
          {m_busy, eg, erdy, een, edone, 1'b0}) begin
        bad++;
        $display("FAIL rand_ctrl cyc%0d: busy=%b gnt=%b rdy=%b en=%b done=%b err=%b, want %b %b %b %b %b 0",
                 cyc, busy, req_gnt, s_ready, fifo_wr_en, burst_done, err_timeout,
                 m_busy, eg, erdy, een, edone);
      end
      if (een) begin
        total++;
        if (fifo_wr_data !== word_of(int'(m_g), m_sent[m_g])) begin
          bad++;
          $display("FAIL rand_data cyc%0d: data=%h, want %h", cyc, fifo_wr_data,
                   word_of(int'(m_g), m_sent[m_g]));
        end
      end
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && req_valid[c]) begin
            found  = 1'b1;
            m_busy = 1'b1;
            m_g    = PW'(c);
            m_left = int'(req_len[c*LW +: LW]);
          end
        end
      end else if (een) begin
        m_sent[m_g]++;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_ptr  = int'(m_g);
        end else begin
          m_left--;
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

`ifdef HDMI_FIFO_WR_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    req_len[3*LW +: LW] = 8'd4;
    req_valid   = 4'b1000;
    s_valid     = 4'b1000;
    fifo_wr_vld = 1'b1;
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    s_valid = 4'b0001;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      total++;
      if (err_timeout !== 1'b0 || burst_done !== '0 || req_gnt !== 4'b1000) begin
        bad++;
        $display("FAIL tmo_stall%0d: err=%b done=%b gnt=%b, want 0 0000 1000",
                 c, err_timeout, burst_done, req_gnt);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (err_timeout !== 1'b1 || burst_done !== '0) begin
      bad++;
      $display("FAIL tmo_pulse: err=%b done=%b, want 1 0000", err_timeout, burst_done);
    end
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle: busy=%b err=%b, want 0 0", busy, err_timeout);
    end
    tick();
    @(negedge clk);
    total++;
    if (req_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL tmo_next_grant: gnt=%b, want 0001", req_gnt);
    end
    idle_inputs();
    tick();
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_long_burst();
    test_reset_mid_burst();
    test_random();
`ifdef HDMI_FIFO_WR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
